// File: rtl/usr_reg_param.sv
// Parametrised universal shift register: hold, shift right/left, parallel load, clock enable,
// synchronous active-low reset and synchronous set to PRESET_VAL. Define USR_ROTATE_EN to add rotate.
module usr_reg_param #(
    parameter int                 WIDTH      = 8,
    parameter logic [WIDTH-1:0]   PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_r,
    output logic             sout_l
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_q_s;
    logic [WIDTH-1:0] shr_s;
    logic [WIDTH-1:0] shl_s;
    logic             in_r_s;
    logic             in_l_s;

`ifdef USR_ROTATE_EN
    // Rotation feeds the departing bit back in place of the serial input.
    assign in_r_s = rot ? q_r[0]       : sin_r;
    assign in_l_s = rot ? q_r[WIDTH-1] : sin_l;
`else
    assign in_r_s = sin_r;
    assign in_l_s = sin_l;
`endif

    generate
        if (WIDTH == 1) begin : g_w1
            assign shr_s = in_r_s;
            assign shl_s = in_l_s;
        end else begin : g_wn
            assign shr_s = {in_r_s, q_r[WIDTH-1:1]};
            assign shl_s = {q_r[WIDTH-2:0], in_l_s};
        end
    endgenerate

    // Mode decode for the enabled, non-reset, non-set case.
    always_comb begin
        next_q_s = q_r;
        if (!en) begin
            next_q_s = q_r;
        end else begin
            case (mode)
                2'b00:   next_q_s = q_r;
                2'b01:   next_q_s = shr_s;
                2'b10:   next_q_s = shl_s;
                2'b11:   next_q_s = d;
                default: next_q_s = q_r;
            endcase
        end
    end

    // State register: reset beats set, set beats enable and mode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_r <= {WIDTH{1'b0}};
        end else if (set) begin
            q_r <= PRESET_VAL;
        end else begin
            q_r <= next_q_s;
        end
    end

    assign q      = q_r;
    assign qbar   = ~q_r;
    assign sout_r = q_r[0];
    assign sout_l = q_r[WIDTH-1];

endmodule

// File: tb/tb_usr_reg_param.sv
// Scoreboard bench for usr_reg_param (WIDTH=8, PRESET_VAL=8'hA5); rotate cases run when
// USR_ROTATE_EN is defined.
module tb_usr_reg_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set = 1'b1;
    logic       en = 1'b1;
    logic [1:0] mode = 2'b11;
    logic [7:0] d = 8'hFF;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic       rot = 1'b0;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       sout_r;
    logic       sout_l;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] m_q = 8'h00;
    logic [7:0] exp_q[$];

    usr_reg_param #(.WIDTH(8), .PRESET_VAL(8'hA5)) dut (
        .clk(clk), .reset(reset), .set(set), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l),
`ifdef USR_ROTATE_EN
        .rot(rot),
`endif
        .q(q), .qbar(qbar), .sout_r(sout_r), .sout_l(sout_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one edge worth of inputs and push the reference result.
    task automatic step(input logic r, input logic s, input logic e, input logic [1:0] md,
                        input logic [7:0] dd, input logic sr, input logic sl, input logic rt);
        int nv;
        int ir;
        int il;
        @(negedge clk);
        reset = r; set = s; en = e; mode = md; d = dd; sin_r = sr; sin_l = sl; rot = rt;
`ifdef USR_ROTATE_EN
        ir = rt ? int'(m_q) % 2 : int'(sr);
        il = rt ? int'(m_q) / 128 : int'(sl);
`else
        ir = int'(sr);
        il = int'(sl);
`endif
        nv = int'(m_q);
        if (!r)      nv = 0;
        else if (s)  nv = 165;
        else if (!e) nv = int'(m_q);
        else if (md == 2'd1) nv = int'(m_q) / 2 + ir * 128;
        else if (md == 2'd2) nv = (int'(m_q) * 2 + il) % 256;
        else if (md == 2'd3) nv = int'(dd);
        m_q = nv[7:0];
        exp_q.push_back(m_q);
    endtask

    // Monitor: compare every output after each edge that has a queued expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("q", q, e);
                check("qbar", qbar, ~e);
                check("sout_r", {7'd0, sout_r}, {7'd0, e[0]});
                check("sout_l", {7'd0, sout_l}, {7'd0, e[7]});
            end
        end
    end

    initial begin
        int waits;
        // reset wins over set, en and load
        step(1'b0, 1'b1, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
        // reset on the 3rd of 8 shift-left edges
        step(1'b1, 1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step((i == 2) ? 1'b0 : 1'b1, 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
`ifdef USR_ROTATE_EN
        step(1'b1, 1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 2'b11, 8'h81, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 1'b1, 2'((i % 2) + 1), 8'h00, i[0], ~i[0], 1'b1);
`endif
        for (int i = 0; i < 400; i++)
            step(($urandom_range(15) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(15) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                 2'($urandom_range(3)), 8'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom));
        waits = 0;
        while (exp_q.size() > 0 && waits < 20) begin
            @(posedge clk);
            waits++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
